// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch/data-stage requesters, the arbiter and the shared single-port RAM.
// Handshake: a requester raises req with addr/we/wdata held stable until its ready pulses for one cycle; rdata is valid only with ready.
interface memory_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 9
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [XLEN-1:0]       if_rdata;
  logic                  if_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic                  mem_ready;
  logic [XLEN-1:0]       mem_rdata;
  logic                  mem_stall;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [XLEN-1:0]       ram_data;
  logic                  ram_wren;
  logic [XLEN-1:0]       ram_q;

  logic [15:0]           conflict_count;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_q,
    output if_ready, if_rdata, if_stall, mem_ready, mem_rdata, mem_stall,
    output ram_address, ram_data, ram_wren, conflict_count
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_q,
    input  if_ready, if_rdata, if_stall, mem_ready, mem_rdata, mem_stall,
    input  ram_address, ram_data, ram_wren, conflict_count
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one registered-address single-port RAM between fetch (IF) and data (MEM) stages.
// Each access takes IDLE/WAIT -> ISSUE (address on RAM) -> WAIT (ready + RAM q); WAIT can hand over straight to the other side.
module memory_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  memory_arbiter_if.slave      bus,
  output logic [1:0]           dbg_state,
  output logic                 dbg_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  state_t      state;
  owner_t      owner;
  owner_t      last_grant;
  owner_t      winner;
  logic        grant;
  logic        issue;
  logic        acc_we;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic [15:0] conflict_q;

  // In WAIT only the side that does not own the finishing access may be granted.
  always_comb begin
    winner = OWN_IF;
    grant  = 1'b0;
    case (state)
      IDLE: begin
        grant = bus.if_req || bus.mem_req;
        if (bus.if_req && bus.mem_req) begin
          winner = (last_grant == OWN_IF) ? OWN_MEM : OWN_IF;
        end else if (bus.mem_req) begin
          winner = OWN_MEM;
        end
      end
      WAIT: begin
        if (owner == OWN_IF) begin
          grant  = bus.mem_req;
          winner = OWN_MEM;
        end else begin
          grant  = bus.if_req;
          winner = OWN_IF;
        end
      end
      default: begin
        grant  = 1'b0;
        winner = OWN_IF;
      end
    endcase
  end

  assign issue           = (state == ISSUE);
  assign bus.ram_wren    = issue && (owner == OWN_MEM) && bus.mem_we;
  assign bus.ram_address = !issue ? {ADDR_WIDTH{1'b0}} :
                           (owner == OWN_MEM) ? bus.mem_addr : bus.if_addr;
  assign bus.ram_data    = issue ? bus.mem_wdata : {XLEN{1'b0}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      last_grant  <= OWN_IF;
      acc_we      <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      conflict_q  <= 16'd0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if (bus.if_req && bus.mem_req && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
      case (state)
        ISSUE: begin
          state       <= WAIT;
          acc_we      <= bus.ram_wren;
          if_ready_q  <= (owner == OWN_IF);
          mem_ready_q <= (owner == OWN_MEM);
        end
        default: begin
          if (grant) begin
            state      <= ISSUE;
            owner      <= winner;
            last_grant <= winner;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // RAM q arrives in WAIT, so read data is passed through rather than registered.
  assign bus.if_ready       = if_ready_q;
  assign bus.mem_ready      = mem_ready_q;
  assign bus.if_rdata       = if_ready_q ? bus.ram_q : {XLEN{1'b0}};
  assign bus.mem_rdata      = (mem_ready_q && !acc_we) ? bus.ram_q : {XLEN{1'b0}};
  assign bus.if_stall       = bus.if_req && !if_ready_q;
  assign bus.mem_stall      = bus.mem_req && !mem_ready_q;
  assign bus.conflict_count = conflict_q;

  assign dbg_state = state;
  assign dbg_owner = owner;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, word address width.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req input 1, if_addr input ADDR_WIDTH: fetch read request and address.
REQ-006 SHALL have ports if_ready output 1, if_rdata output XLEN: fetch completion pulse and read data.
REQ-007 SHALL have ports mem_req input 1, mem_we input 1, mem_addr input ADDR_WIDTH, mem_wdata input XLEN: data-stage request.
REQ-008 SHALL have ports mem_ready output 1, mem_rdata output XLEN: data-stage completion pulse and read data.
REQ-009 SHALL have ports ram_address output ADDR_WIDTH, ram_data output XLEN, ram_wren output 1, ram_q input XLEN: the shared single-port RAM, which registers its address and returns q one cycle later.
REQ-010 SHALL have ports if_stall output 1, mem_stall output 1: pipeline hold requests.
REQ-011 SHALL have port conflict_count output 16: count of cycles with both requests pending.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, plus a registered owner (IF or MEM) and a registered last_grant.
REQ-013 In IDLE, if any req is high, SHALL register the winner as owner, update last_grant and go to ISSUE; otherwise stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: a single requester wins; on contention the requester not equal to last_grant wins.
REQ-015 In ISSUE, SHALL drive ram_address from the owner's address and assert ram_wren = (owner==MEM && mem_we), with ram_data = mem_wdata; then go to WAIT.
REQ-016 Outside ISSUE, ram_wren SHALL be 0; ram_address and ram_data SHALL be 0.
REQ-017 In WAIT, SHALL assert the owner's ready for exactly that cycle; the owner's rdata SHALL equal ram_q for a read and 0 for a write.
REQ-018 The non-owner ready SHALL be 0 in every state; rdata SHALL be 0 whenever its ready is 0.
REQ-019 In WAIT, if the non-owner req is high, SHALL grant it (owner, last_grant updated) and go to ISSUE; otherwise go to IDLE. The current owner's still-high req SHALL be ignored in WAIT.
REQ-020 Uncontended access latency SHALL be: req seen in IDLE at cycle 0, ISSUE at cycle 1, ready at cycle 2.
REQ-021 Under permanent contention, grants SHALL alternate, with one completion every 2 cycles.
REQ-022 Requesters SHALL hold req, addr, we and wdata stable until ready; if req drops early, the access SHALL still complete and ready SHALL still pulse.
REQ-023 if_stall SHALL equal if_req && !if_ready; mem_stall SHALL equal mem_req && !mem_ready.
REQ-024 conflict_count SHALL increment by 1 in each cycle with if_req && mem_req, and SHALL saturate at 16'hFFFF.
REQ-025 The arbiter SHALL never issue more than one RAM access per cycle and SHALL never assert both readies in the same cycle.

Reset
REQ-026 reset low SHALL asynchronously force: state IDLE, owner IF, last_grant IF, conflict_count 0.
REQ-027 reset low SHALL asynchronously force to 0: if_ready, mem_ready, if_rdata, mem_rdata, ram_wren, ram_address and ram_data.
REQ-028 An access in flight at reset SHALL be abandoned with no ready pulse; a write in ISSUE SHALL have ram_wren deasserted immediately.
REQ-029 After reset release, the first contended grant SHALL go to MEM.

Verification
REQ-030 Single fetch: if_req=1, if_addr=0x010, RAM[0x010]=0xDEADBEEF -> if_ready=1 with if_rdata=0xDEADBEEF exactly 2 cycles later; if_stall=1 for cycles 0-1.
REQ-031 Write then read: mem_we=1, mem_addr=0x1FF, wdata=0x12345678 -> ram_wren=1 only in ISSUE, mem_ready at cycle 2; a subsequent read of 0x1FF returns 0x12345678.
REQ-032 Contention: both req high from reset release for 6 completions -> order MEM, IF, MEM, IF, MEM, IF, one ready every 2 cycles, conflict_count=12 after 12 cycles.
REQ-033 Back-to-back: mem_req rises during IF's WAIT -> MEM enters ISSUE the next cycle, with no IDLE cycle between.
REQ-034 Reset mid-write: assert reset during ISSUE of a mem write -> ram_wren falls within the same cycle, no mem_ready pulse, state IDLE after release.
REQ-035 Saturation: force 70000 cycles of dual requests -> conflict_count holds 16'hFFFF.
